// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg
// Shared constants and encodings for the change dispenser. The vending
// controller uses the same item and state encodings.
package change_dispenser_pkg;

  localparam int VAL_W     = 5;    // whole-unit amount width
  localparam int MAX_VAL   = 16;   // largest request that is accepted
  localparam int EJECT_CYC = 4;    // eject pulse width, cycles
  localparam int TIMEOUT   = 255;  // eject rise to sense, cycles
  localparam int GAP_CYC   = 2;    // idle cycles between ejections
  localparam int TMR_W     = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SELECT     = 3'd1,
    ST_EJECT      = 3'd2,
    ST_WAIT_SENSE = 3'd3,
    ST_GAP        = 3'd4,
    ST_ERR        = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ITEM_NONE = 2'd0,
    ITEM_TEN  = 2'd1,
    ITEM_ONE  = 2'd2,
    ITEM_HALF = 2'd3
  } item_t;

endpackage

// File: rtl/change_dispenser_timer.sv
// change_dispenser_timer
// Loadable down-counter with a zero flag. The dispenser reuses one instance
// for the eject pulse width, the sense timeout and the inter-item gap.
// Ports:
//   clk_N   clock, rising edge
//   reset   synchronous reset, active-low
//   i_load  load i_val this cycle (wins over counting)
//   i_val   load value
//   o_zero  counter is zero; it holds at zero until reloaded
module change_dispenser_timer #(
  parameter int W = 8
) (
  input  logic         clk_N,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_N) begin
    if (!reset)               r_cnt <= '0;
    else if (i_load)          r_cnt <= i_val;
    else if (r_cnt != '0)     r_cnt <= r_cnt - W'(1);
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser
// Pays out a change request one item at a time (10-note, 1-coin, 0.5-coin),
// confirming each item on the hopper exit sensor before choosing the next.
// Ports:
//   clk_N, reset           clock / synchronous active-low reset
//   charge_req/val/float   request strobe and amount (whole units + half)
//   ten/one/half_empty     hopper stock flags, looked at when choosing an item
//   coin_sense             hopper exit sensor, one rising edge per item
//   clear_err              leaves the error state
//   req_ready, busy        idle-and-clean / request in progress
//   eject_ten/one/half     eject strobes, at most one high
//   done                   1-cycle pulse, request fully paid
//   jam, short_pay         sticky error flags
//   remain_val/float       amount still unpaid
module change_dispenser
  import change_dispenser_pkg::*;
(
  input  logic             clk_N,
  input  logic             reset,
  input  logic             charge_req,
  input  logic [VAL_W-1:0] charge_val,
  input  logic             charge_float,
  input  logic             ten_empty,
  input  logic             one_empty,
  input  logic             half_empty,
  input  logic             coin_sense,
  input  logic             clear_err,
  output logic             req_ready,
  output logic             busy,
  output logic             eject_ten,
  output logic             eject_one,
  output logic             eject_half,
  output logic             done,
  output logic             jam,
  output logic             short_pay,
  output logic [VAL_W-1:0] remain_val,
  output logic             remain_float
);

  state_t           r_state, w_next;
  item_t            r_item, w_sel;
  logic [VAL_W-1:0] r_rv;
  logic             r_rf, r_done, r_jam, r_short;
  logic             r_sense, r_sense_d, r_got;
  logic             w_rise, w_nonzero, w_accept;
  logic             w_tmr_load, w_tmr_zero;
  logic [TMR_W-1:0] w_tmr_val;

  assign w_rise    = r_sense & ~r_sense_d;
  assign w_nonzero = (r_rv != '0) | r_rf;
  // A sense edge seen during EJECT is remembered in r_got and consumed here.
  assign w_accept  = r_got | w_rise;

  // Greedy choice: tens first, then ones, halves only for the half unit.
  always_comb begin
    w_sel = ITEM_NONE;
    if (r_rv >= VAL_W'(10) && !ten_empty)  w_sel = ITEM_TEN;
    else if (r_rv != '0 && !one_empty)     w_sel = ITEM_ONE;
    else if (r_rf && !half_empty)          w_sel = ITEM_HALF;
  end

  always_ff @(posedge clk_N) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      ST_IDLE:
        if (charge_req)
          w_next = (charge_val > VAL_W'(MAX_VAL)) ? ST_ERR : ST_SELECT;
      ST_SELECT:
        if (w_sel != ITEM_NONE) begin
          w_next     = ST_EJECT;
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(EJECT_CYC - 1);
        end else begin
          w_next = w_nonzero ? ST_ERR : ST_IDLE;
        end
      ST_EJECT:
        if (w_tmr_zero) begin
          // Timeout is measured from eject rise, so subtract the pulse length.
          w_next     = ST_WAIT_SENSE;
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(TIMEOUT - EJECT_CYC - 1);
        end
      ST_WAIT_SENSE:
        if (w_accept) begin
          w_next     = ST_GAP;
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(GAP_CYC - 1);
        end else if (w_tmr_zero) begin
          w_next = ST_ERR;
        end
      ST_GAP:
        if (w_tmr_zero) w_next = ST_SELECT;
      ST_ERR:
        if (clear_err) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  change_dispenser_timer #(.W(TMR_W)) u_timer (
    .clk_N  (clk_N),
    .reset  (reset),
    .i_load (w_tmr_load),
    .i_val  (w_tmr_val),
    .o_zero (w_tmr_zero)
  );

  always_ff @(posedge clk_N) begin
    if (!reset) begin
      r_rv      <= '0;
      r_rf      <= 1'b0;
      r_item    <= ITEM_NONE;
      r_done    <= 1'b0;
      r_jam     <= 1'b0;
      r_short   <= 1'b0;
      r_got     <= 1'b0;
      r_sense   <= 1'b0;
      r_sense_d <= 1'b0;
    end else begin
      r_sense   <= coin_sense;
      r_sense_d <= r_sense;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE:
          if (charge_req) begin
            r_rv <= charge_val;
            r_rf <= charge_float;
            if (charge_val > VAL_W'(MAX_VAL)) r_short <= 1'b1;
          end
        ST_SELECT: begin
          r_item <= w_sel;
          r_got  <= 1'b0;
          if (w_sel == ITEM_NONE) begin
            if (w_nonzero) r_short <= 1'b1;
            else           r_done  <= 1'b1;
          end
        end
        ST_EJECT:
          if (w_rise) r_got <= 1'b1;
        ST_WAIT_SENSE:
          if (w_accept) begin
            case (r_item)
              ITEM_TEN:  r_rv <= r_rv - VAL_W'(10);
              ITEM_ONE:  r_rv <= r_rv - VAL_W'(1);
              ITEM_HALF: r_rf <= 1'b0;
              default:   ;
            endcase
          end else if (w_tmr_zero) begin
            r_jam <= 1'b1;
          end
        ST_ERR:
          if (clear_err) begin
            r_jam   <= 1'b0;
            r_short <= 1'b0;
          end
        default: ;
      endcase
    end
  end

  assign req_ready    = (r_state == ST_IDLE);
  assign busy         = (r_state == ST_SELECT) || (r_state == ST_EJECT) ||
                        (r_state == ST_WAIT_SENSE) || (r_state == ST_GAP);
  assign eject_ten    = (r_state == ST_EJECT) && (r_item == ITEM_TEN);
  assign eject_one    = (r_state == ST_EJECT) && (r_item == ITEM_ONE);
  assign eject_half   = (r_state == ST_EJECT) && (r_item == ITEM_HALF);
  assign done         = r_done;
  assign jam          = r_jam;
  assign short_pay    = r_short;
  assign remain_val   = r_rv;
  assign remain_float = r_rf;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a transaction-level model predicts the item
// order, final outcome and remainder; a per-cycle monitor checks eject
// behaviour and answers each eject with a sensor pulse.
module tb_change_dispenser;

  localparam int T_MAX = 16;
  localparam int T_EJ  = 4;
  localparam int T_TO  = 255;

  logic       clk_N = 1'b0, reset = 1'b0, charge_req = 1'b0, charge_float = 1'b0;
  logic       ten_empty = 1'b0, one_empty = 1'b0, half_empty = 1'b0;
  logic       coin_sense = 1'b0, clear_err = 1'b0;
  logic [4:0] charge_val = '0;
  logic       req_ready, busy, eject_ten, eject_one, eject_half, done, jam, short_pay;
  logic [4:0] remain_val;
  logic       remain_float;

  change_dispenser dut (
    .clk_N(clk_N), .reset(reset), .charge_req(charge_req), .charge_val(charge_val),
    .charge_float(charge_float), .ten_empty(ten_empty), .one_empty(one_empty),
    .half_empty(half_empty), .coin_sense(coin_sense), .clear_err(clear_err),
    .req_ready(req_ready), .busy(busy), .eject_ten(eject_ten), .eject_one(eject_one),
    .eject_half(eject_half), .done(done), .jam(jam), .short_pay(short_pay),
    .remain_val(remain_val), .remain_float(remain_float)
  );

  always #5 clk_N = ~clk_N;

  int cyc = 0;
  always @(posedge clk_N) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // item codes: 1 ten, 2 one, 3 half, 0 nothing payable
  function automatic int pick(input int rv, input bit rf, input bit te, input bit oe, input bit he);
    if (rv >= 10 && !te) return 1;
    if (rv >= 1 && !oe)  return 2;
    if (rf && !he)       return 3;
    return 0;
  endfunction

  // model state shared between stimulus and monitor
  int m_rv = 0;
  bit m_rf = 0, m_sense_on = 0, m_dbl = 0;
  int n_ej = 0;
  int q_items[$];
  int t_res, t_rv, t_rf, t_k;

  // drive / check point: well after the rising edge
  task automatic tick();
    @(posedge clk_N);
    #2;
  endtask

  // per-cycle monitor + sensor responder
  initial begin
    logic [2:0] prev_ej = '0, ej;
    bit prev_jam = 0;
    int w_cnt = 0, rise_cyc = 0, s_dly = -1, s_hi = 1, s_cnt = 0, it, ex;
    bit s_dbl = 0;
    forever begin
      @(posedge clk_N);
      #1;
      if (!reset) begin
        prev_ej = '0; w_cnt = 0; s_dly = -1; s_dbl = 0; coin_sense = 1'b0; prev_jam = 0;
      end else begin
        ej = {eject_ten, eject_one, eject_half};
        chk($onehot0(ej) && !(busy && req_ready), "onehot_busy", {ej, busy, req_ready}, 0);
        if (ej != 0 && prev_ej == 0) begin
          it = ej[2] ? 1 : (ej[1] ? 2 : 3);
          ex = pick(m_rv, m_rf, ten_empty, one_empty, half_empty);
          chk(it == ex, "item", it, ex);
          q_items.push_back(it);
          n_ej++;
          rise_cyc = cyc;
          if (m_sense_on) begin
            if (it == 1) m_rv -= 10;
            else if (it == 2) m_rv -= 1;
            else m_rf = 0;
            s_dly = m_dbl ? 0 : $urandom_range(0, 20);
            s_hi  = m_dbl ? 1 : $urandom_range(1, 2);
            s_dbl = m_dbl;
          end
        end
        if (ej != 0) w_cnt++;
        else if (prev_ej != 0) begin
          chk(w_cnt == T_EJ, "eject_width", w_cnt, T_EJ);
          w_cnt = 0;
        end
        if (jam && !prev_jam) chk(cyc - rise_cyc == T_TO, "jam_delay", cyc - rise_cyc, T_TO);
        prev_jam = jam;
        prev_ej  = ej;
        if (coin_sense) begin
          s_cnt--;
          if (s_cnt <= 0) begin
            coin_sense = 1'b0;
            if (s_dbl) begin s_dbl = 0; s_dly = 1; end
          end
        end else if (s_dly == 0) begin
          coin_sense = 1'b1; s_cnt = s_hi; s_dly = -1;
        end else if (s_dly > 0) s_dly--;
      end
    end
  end

  // smode: 0 no sensor (jam), 1 single pulse random delay, 2 double pulse
  task automatic run_txn(input int v, input bit f, input bit te, input bit oe, input bit he,
                         input int smode, input bit poke);
    int rv = v, e_n = 0, e_res = 0, it, k, sv, sf;
    bit rf = f, got = 0, poked = 0;
    if (v > T_MAX) e_res = 1;
    else forever begin
      it = pick(rv, rf, te, oe, he);
      if (it == 0) begin e_res = (rv != 0 || rf) ? 1 : 0; break; end
      e_n++;
      if (smode == 0) begin e_res = 2; break; end
      if (it == 1) rv -= 10; else if (it == 2) rv -= 1; else rf = 0;
    end
    ten_empty = te; one_empty = oe; half_empty = he;
    m_rv = v; m_rf = f; m_sense_on = (smode != 0); m_dbl = (smode == 2);
    n_ej = 0; q_items.delete();
    for (k = 0; k < 50 && !req_ready; k++) tick();
    chk(req_ready, "ready_wait", req_ready, 1);
    charge_req = 1'b1; charge_val = 5'(v); charge_float = f;
    tick();
    charge_req = 1'b0; charge_val = 5'($urandom); charge_float = 1'($urandom);
    chk(busy == (v <= T_MAX), "busy_after_req", busy, v <= T_MAX);
    for (k = 0; k < 6000; k++) begin
      if (done || short_pay || jam) begin got = 1; break; end
      if (poke && !poked && (eject_ten || eject_one || eject_half)) begin
        sv = remain_val; sf = remain_float;
        charge_req = 1'b1; charge_val = 5'd3; charge_float = 1'b1;
        tick();
        charge_req = 1'b0;
        chk(remain_val == sv && remain_float == sf, "busy_req_ignored", remain_val, sv);
        poked = 1;
        continue;
      end
      tick();
    end
    chk(got, "terminal_timeout", got, 1);
    t_res = done ? 0 : (short_pay ? 1 : 2);
    t_rv = remain_val; t_rf = remain_float; t_k = k;
    chk(t_res == e_res, "outcome", t_res, e_res);
    chk(t_rv == rv && t_rf == rf, "remain", t_rv * 2 + t_rf, rv * 2 + rf);
    chk(n_ej == e_n, "eject_count", n_ej, e_n);
    if (v > T_MAX) chk(t_k == 0, "reject_latency", t_k, 0);
    else if (e_n == 0) chk(t_k == 1, "no_eject_latency", t_k, 1);
    if (t_res == 0) begin
      tick();
      chk(!done && req_ready && !busy, "done_pulse", {done, req_ready, busy}, 3'b010);
    end else begin
      charge_req = 1'b1; charge_val = 5'd1;
      tick();
      charge_req = 1'b0;
      chk(!req_ready && !busy && (jam || short_pay) && remain_val == 5'(t_rv),
          "err_hold", {req_ready, busy, jam, short_pay}, t_res == 2 ? 4'b0010 : 4'b0001);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk(req_ready && !jam && !short_pay, "clear_err", {req_ready, jam, short_pay}, 3'b100);
    end
  endtask

  initial begin
    bit all_one;
    int k;
    reset = 1'b0;
    repeat (3) tick();
    chk({req_ready, busy, eject_ten, eject_one, eject_half, done, jam, short_pay,
         remain_val, remain_float} == 14'b10000000000000, "reset_state",
        {req_ready, busy, done, jam, short_pay}, 5'b10000);
    reset = 1'b1;
    tick();

    // 13.5 with full stock, plus a request poked in mid-payout
    run_txn(13, 1, 0, 0, 0, 1, 1);
    chk(q_items.size() == 5, "t1_count", q_items.size(), 5);
    if (q_items.size() == 5)
      chk(q_items[0] == 1 && q_items[1] == 2 && q_items[2] == 2 && q_items[3] == 2 &&
          q_items[4] == 3, "t1_order", q_items[0] * 10000 + q_items[1] * 1000 +
          q_items[2] * 100 + q_items[3] * 10 + q_items[4], 12223);
    // tens hopper empty: twelve ones, double sensor pulses
    run_txn(12, 0, 1, 0, 0, 2, 0);
    all_one = (q_items.size() == 12);
    foreach (q_items[i]) if (q_items[i] != 2) all_one = 0;
    chk(all_one, "t2_all_ones", q_items.size(), 12);
    chk(t_res == 0, "t2_done", t_res, 0);
    // no sensor: jam
    run_txn(1, 0, 0, 0, 0, 0, 0);
    chk(t_res == 2 && t_rv == 1, "t3_jam_remain", t_rv, 1);
    // half unpayable, and oversize request
    run_txn(0, 1, 0, 0, 1, 1, 0);
    chk(t_res == 1 && t_rf == 1 && t_k == 1, "t4_short_half", t_k, 1);
    run_txn(20, 0, 0, 0, 0, 1, 0);
    chk(t_res == 1 && t_rv == 20 && t_k == 0, "t4_short_big", t_rv, 20);

    // reset in the 2nd cycle of EJECT
    ten_empty = 0; one_empty = 0; half_empty = 0;
    m_rv = 1; m_rf = 0; m_sense_on = 1; m_dbl = 0; n_ej = 0;
    charge_req = 1'b1; charge_val = 5'd1; charge_float = 1'b0;
    tick();
    charge_req = 1'b0;
    for (k = 0; k < 20 && !eject_one; k++) tick();
    chk(eject_one, "t5_eject_seen", eject_one, 1);
    tick();
    reset = 1'b0;
    tick();
    chk({req_ready, busy, eject_ten, eject_one, eject_half, done, jam, short_pay,
         remain_val, remain_float} == 14'b10000000000000, "t5_mid_reset",
        {req_ready, busy, eject_one, remain_val}, 8'b10000000);
    reset = 1'b1;
    tick();
    run_txn(1, 0, 0, 0, 0, 1, 0);
    chk(t_res == 0 && n_ej == 1, "t5_after_reset", n_ej, 1);

    // zero request
    run_txn(0, 0, 0, 0, 0, 1, 0);
    chk(t_res == 0 && t_k == 1, "t6_zero_done", t_k, 1);

    for (int i = 0; i < 40; i++) begin
      int v, sm;
      v  = $urandom_range(0, 20);
      sm = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 2);
      run_txn(v, 1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, sm, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
